// File: rtl/eh2_lsu_amo_wrbuf_if.sv
// AMO write-buffer bus bundle.
// Groups the dc3 AMO push side, the dc2 forwarding lookup and the DCCM
// write port of eh2_lsu_amo_wrbuf.
//   slave  : the write buffer itself (receives AMOs, drives DCCM requests)
//   master : the surrounding LSU pipe / DCCM model (drives AMOs, ready)
interface eh2_lsu_amo_wrbuf_if #(
  parameter int unsigned ADDRW = 16
);
  // dc3 AMO push side
  logic             amo_valid_dc3;
  logic             flush_dc3;
  logic             amo_tid_dc3;
  logic [ADDRW-1:0] amo_addr_dc3;
  logic [31:0]      amo_data_dc3;
  logic             amo_stall_dc3;
  // dc2 forwarding lookup
  logic [ADDRW-1:0] lkup_addr_dc2;
  logic             fwd_hit_dc2;
  logic [31:0]      fwd_data_dc2;
  // DCCM write port
  logic             dccm_wr_req;
  logic             dccm_wr_ready;
  logic [ADDRW-1:0] dccm_wr_addr;
  logic [31:0]      dccm_wr_data;
  logic             dccm_wr_tid;
  // status
  logic             amo_buf_empty;

  modport slave (
    input  amo_valid_dc3, flush_dc3, amo_tid_dc3, amo_addr_dc3, amo_data_dc3,
    input  lkup_addr_dc2, dccm_wr_ready,
    output amo_stall_dc3, fwd_hit_dc2, fwd_data_dc2,
    output dccm_wr_req, dccm_wr_addr, dccm_wr_data, dccm_wr_tid, amo_buf_empty
  );

  modport master (
    output amo_valid_dc3, flush_dc3, amo_tid_dc3, amo_addr_dc3, amo_data_dc3,
    output lkup_addr_dc2, dccm_wr_ready,
    input  amo_stall_dc3, fwd_hit_dc2, fwd_data_dc2,
    input  dccm_wr_req, dccm_wr_addr, dccm_wr_data, dccm_wr_tid, amo_buf_empty
  );
endinterface

// File: rtl/eh2_lsu_amo_wrbuf.sv
// In-order write buffer for AMO/SC results heading to the DCCM.
// Entries are pushed from dc3, drained one per accepted DCCM write, and
// forwarded to a dc2 lookup by word address (youngest match wins).
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : eh2_lsu_amo_wrbuf_if.slave (AMO push, dc2 lookup, DCCM write port)
module eh2_lsu_amo_wrbuf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ADDRW = 16
) (
  input logic                 clk,
  input logic                 rst,
  eh2_lsu_amo_wrbuf_if.slave  bus
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [ADDRW-1:0] addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] tid_q;

  logic full, empty, push, pop, wr_req;

  assign full   = (count_q == CNTW'(DEPTH));
  assign empty  = (count_q == '0);
  // Stall looks only at the current count; a same-cycle pop does not
  // free a slot for this cycle's AMO.
  assign push   = bus.amo_valid_dc3 & ~bus.flush_dc3 & ~full & ~rst;
  assign wr_req = ~empty & ~rst;
  assign pop    = wr_req & bus.dccm_wr_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTRW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTRW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset: it is only observed through valid
  // entries, and the outputs are zeroed while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.amo_addr_dc3;
      data_q[wr_ptr_q] <= bus.amo_data_dc3;
      tid_q[wr_ptr_q]  <= bus.amo_tid_dc3;
    end
  end

  assign bus.amo_stall_dc3 = full & ~rst;
  assign bus.amo_buf_empty = ~wr_req;
  assign bus.dccm_wr_req   = wr_req;
  assign bus.dccm_wr_addr  = wr_req ? addr_q[rd_ptr_q] : '0;
  assign bus.dccm_wr_data  = wr_req ? data_q[rd_ptr_q] : '0;
  assign bus.dccm_wr_tid   = wr_req ? tid_q[rd_ptr_q]  : 1'b0;

  // Forwarding: walk entries oldest to youngest so later matches override,
  // then let the same-cycle push (youngest of all) override. An entry being
  // popped this cycle is still valid here and therefore still forwards.
  logic [PTRW-1:0] fidx;
  logic            fhit;
  logic [31:0]     fdata;

  always_comb begin
    fhit  = 1'b0;
    fdata = '0;
    fidx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr_q + PTRW'(k);
      if (valid_q[fidx] &&
          (addr_q[fidx][ADDRW-1:2] == bus.lkup_addr_dc2[ADDRW-1:2])) begin
        fhit  = 1'b1;
        fdata = data_q[fidx];
      end
    end
    if (push && (bus.amo_addr_dc3[ADDRW-1:2] == bus.lkup_addr_dc2[ADDRW-1:2])) begin
      fhit  = 1'b1;
      fdata = bus.amo_data_dc3;
    end
    if (rst) begin
      fhit  = 1'b0;
      fdata = '0;
    end
  end

  assign bus.fwd_hit_dc2  = fhit;
  assign bus.fwd_data_dc2 = fdata;

endmodule

// File: tb/tb_eh2_lsu_amo_wrbuf.sv
module tb_eh2_lsu_amo_wrbuf;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 16;

  logic clk;
  logic rst;

  eh2_lsu_amo_wrbuf_if #(.ADDRW(AW)) bus  ();
  eh2_lsu_amo_wrbuf_if #(.ADDRW(AW)) bus4 ();

  eh2_lsu_amo_wrbuf #(.DEPTH(DEPTH), .ADDRW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Deeper instance so two pending entries plus a push can coexist.
  eh2_lsu_amo_wrbuf #(.DEPTH(4), .ADDRW(AW)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: FIFO of pending writes --------------
  typedef struct {
    logic        tid;
    logic [15:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  task automatic drive(input logic r, input logic v, input logic fl, input logic tid,
                       input logic [15:0] addr, input logic [31:0] data,
                       input logic [15:0] lkup, input logic rdy);
    rst               = r;
    bus.amo_valid_dc3 = v;
    bus.flush_dc3     = fl;
    bus.amo_tid_dc3   = tid;
    bus.amo_addr_dc3  = addr;
    bus.amo_data_dc3  = data;
    bus.lkup_addr_dc2 = lkup;
    bus.dccm_wr_ready = rdy;
    #1;
  endtask

  task automatic tick();
    logic m_push, m_pop;
    ent_t e;
    m_push = bus.amo_valid_dc3 && !bus.flush_dc3 && (mq.size() < DEPTH);
    m_pop  = (mq.size() > 0) && bus.dccm_wr_ready;
    e.tid  = bus.amo_tid_dc3;
    e.addr = bus.amo_addr_dc3;
    e.data = bus.amo_data_dc3;
    @(posedge clk);
    #1;
    if (rst) mq.delete();
    else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(e);
    end
  endtask

  task automatic cmp_outs(input string tag, input logic e_stall, input logic e_req,
                          input logic e_tid, input logic [15:0] e_waddr,
                          input logic [31:0] e_wdata, input logic e_hit,
                          input logic [31:0] e_fdata, input logic e_empty);
    chk({tag, ".stall"}, bus.amo_stall_dc3, e_stall);
    chk({tag, ".req"},   bus.dccm_wr_req,   e_req);
    chk({tag, ".tid"},   bus.dccm_wr_tid,   e_tid);
    chk({tag, ".waddr"}, bus.dccm_wr_addr,  e_waddr);
    chk({tag, ".wdata"}, bus.dccm_wr_data,  e_wdata);
    chk({tag, ".hit"},   bus.fwd_hit_dc2,   e_hit);
    chk({tag, ".fdata"}, bus.fwd_data_dc2,  e_fdata);
    chk({tag, ".empty"}, bus.amo_buf_empty, e_empty);
  endtask

  task automatic model_check(input string tag);
    logic        m_push, hit, req;
    logic [31:0] fd;
    m_push = bus.amo_valid_dc3 && !bus.flush_dc3 && (mq.size() < DEPTH) && !rst;
    req    = !rst && (mq.size() > 0);
    hit    = 1'b0;
    fd     = '0;
    if (!rst) begin
      foreach (mq[i])
        if (mq[i].addr[15:2] == bus.lkup_addr_dc2[15:2]) begin
          hit = 1'b1;
          fd  = mq[i].data;
        end
      if (m_push && bus.amo_addr_dc3[15:2] == bus.lkup_addr_dc2[15:2]) begin
        hit = 1'b1;
        fd  = bus.amo_data_dc3;
      end
    end
    cmp_outs(tag, !rst && (mq.size() == DEPTH), req,
             req ? mq[0].tid : 1'b0, req ? mq[0].addr : 16'h0,
             req ? mq[0].data : 32'h0, hit, fd, !req);
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic        rst, v, fl, tid;
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] lkup;
    logic        rdy;
    logic        e_stall, e_req, e_tid;
    logic [15:0] e_waddr;
    logic [31:0] e_wdata;
    logic        e_hit;
    logic [31:0] e_fdata;
    logic        e_empty;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic fl, input logic tid,
                              input logic [15:0] addr, input logic [31:0] data,
                              input logic [15:0] lkup, input logic rdy,
                              input logic es, input logic er, input logic et,
                              input logic [15:0] ea, input logic [31:0] ed,
                              input logic eh, input logic [31:0] ef, input logic ee);
    vec_t x;
    x.rst = r; x.v = v; x.fl = fl; x.tid = tid; x.addr = addr; x.data = data;
    x.lkup = lkup; x.rdy = rdy;
    x.e_stall = es; x.e_req = er; x.e_tid = et; x.e_waddr = ea; x.e_wdata = ed;
    x.e_hit = eh; x.e_fdata = ef; x.e_empty = ee;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  initial begin
    int unsigned wr_seen;
    int n;

    bus4.amo_valid_dc3 = 1'b0; bus4.flush_dc3 = 1'b0; bus4.amo_tid_dc3 = 1'b0;
    bus4.amo_addr_dc3  = '0;   bus4.amo_data_dc3 = '0; bus4.lkup_addr_dc2 = '0;
    bus4.dccm_wr_ready = 1'b0;

    //             rst v fl t addr     data          lkup     r | st rq t waddr   wdata         h fdata         e
    tbl.push_back(mk(1,1,0,0,16'h0300,32'h00005555,16'h0300,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0300,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,0,16'h0100,32'hDEADBEEF,16'h0100,1,  0,0,0,16'h0000,32'h00000000,1,32'hDEADBEEF,1));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0100,1,  0,1,0,16'h0100,32'hDEADBEEF,1,32'hDEADBEEF,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0100,1,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,1,16'h0010,32'h11111111,16'h0000,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,0,16'h0020,32'h22222222,16'h0000,0,  0,1,1,16'h0010,32'h11111111,0,32'h00000000,0));
    tbl.push_back(mk(0,1,0,1,16'h0030,32'h33333333,16'h0030,0,  1,1,1,16'h0010,32'h11111111,0,32'h00000000,0));
    tbl.push_back(mk(0,1,0,1,16'h0030,32'h33333333,16'h0020,1,  1,1,1,16'h0010,32'h11111111,1,32'h22222222,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0020,1,  0,1,0,16'h0020,32'h22222222,1,32'h22222222,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0020,1,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,0,16'h0200,32'h0000000A,16'h0204,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,1,16'h0202,32'h0000000C,16'h0201,0,  0,1,0,16'h0200,32'h0000000A,1,32'h0000000C,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0203,0,  1,1,0,16'h0200,32'h0000000A,1,32'h0000000C,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0200,1,  1,1,0,16'h0200,32'h0000000A,1,32'h0000000C,0));
    tbl.push_back(mk(0,1,1,0,16'h0300,32'h00000077,16'h0300,0,  0,1,1,16'h0202,32'h0000000C,0,32'h00000000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0300,0,  0,1,1,16'h0202,32'h0000000C,0,32'h00000000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0000,1,  0,1,1,16'h0202,32'h0000000C,0,32'h00000000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0000,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,0,16'h0400,32'h00000044,16'h0000,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,1,0,1,16'h0404,32'h00000055,16'h0000,0,  0,1,0,16'h0400,32'h00000044,0,32'h00000000,0));
    tbl.push_back(mk(1,1,0,0,16'h0500,32'h00000066,16'h0400,0,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0400,1,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));
    tbl.push_back(mk(0,0,0,0,16'h0000,32'h00000000,16'h0500,1,  0,0,0,16'h0000,32'h00000000,0,32'h00000000,1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].fl, tbl[i].tid, tbl[i].addr, tbl[i].data,
            tbl[i].lkup, tbl[i].rdy);
      cmp_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_req, tbl[i].e_tid,
               tbl[i].e_waddr, tbl[i].e_wdata, tbl[i].e_hit, tbl[i].e_fdata, tbl[i].e_empty);
      tick();
    end

    // ---- 10 back-to-back pushes with ready every cycle (DEPTH=2 wrap) ----
    wr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, i[0], 16'h0040 + 16'(4 * i), 32'hC0DE0000 + i, 16'h0000, 1);
      chk($sformatf("b2b%0d.stall", i), bus.amo_stall_dc3, 1'b0);
      if (i > 0) begin
        chk($sformatf("b2b%0d.req", i), bus.dccm_wr_req, 1'b1);
        chk($sformatf("b2b%0d.wdata", i), bus.dccm_wr_data, 32'hC0DE0000 + i - 1);
      end
      if (bus.dccm_wr_req && bus.dccm_wr_ready) wr_seen++;
      tick();
    end
    drive(0, 0, 0, 0, 16'h0000, 32'h0, 16'h0000, 1);
    chk("b2b_last.wdata", bus.dccm_wr_data, 32'hC0DE0009);
    n = 0;
    while (!bus.amo_buf_empty && n < 8) begin
      if (bus.dccm_wr_req && bus.dccm_wr_ready) wr_seen++;
      tick();
      n++;
    end
    chk("b2b.drain_empty", bus.amo_buf_empty, 1'b1);
    chk("b2b.write_count", wr_seen, 10);

    // ---- forwarding priority on the deeper instance ----
    drive(1, 0, 0, 0, 16'h0000, 32'h0, 16'h0000, 0);
    tick();
    drive(0, 0, 0, 0, 16'h0000, 32'h0, 16'h0000, 0);
    bus4.amo_valid_dc3 = 1; bus4.amo_addr_dc3 = 16'h0200; bus4.amo_data_dc3 = 32'hA;
    #1; tick();
    bus4.amo_addr_dc3 = 16'h0204; bus4.amo_data_dc3 = 32'hB;
    #1; tick();
    bus4.amo_addr_dc3 = 16'h0202; bus4.amo_data_dc3 = 32'hC; bus4.lkup_addr_dc2 = 16'h0201;
    #1;
    chk("prio.push.stall", bus4.amo_stall_dc3, 1'b0);
    chk("prio.push.hit",   bus4.fwd_hit_dc2,   1'b1);
    chk("prio.push.fdata", bus4.fwd_data_dc2,  32'hC);
    tick();
    bus4.amo_valid_dc3 = 0;
    #1;
    chk("prio.entry.fdata", bus4.fwd_data_dc2, 32'hC);
    bus4.lkup_addr_dc2 = 16'h0206;
    #1;
    chk("prio.b.hit",   bus4.fwd_hit_dc2,  1'b1);
    chk("prio.b.fdata", bus4.fwd_data_dc2, 32'hB);
    bus4.lkup_addr_dc2 = 16'h0300;
    #1;
    chk("prio.miss.hit",   bus4.fwd_hit_dc2,  1'b0);
    chk("prio.miss.fdata", bus4.fwd_data_dc2, 32'h0);
    bus4.dccm_wr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("prio.drain%0d.req", i), bus4.dccm_wr_req, 1'b1);
      chk($sformatf("prio.drain%0d.waddr", i), bus4.dccm_wr_addr,
          (i == 0) ? 16'h0200 : (i == 1) ? 16'h0204 : 16'h0202);
      tick();
    end
    #1;
    chk("prio.empty", bus4.amo_buf_empty, 1'b1);
    bus4.dccm_wr_ready = 0;

    // ---- randomized traffic against the queue model ----
    drive(1, 0, 0, 0, 16'h0000, 32'h0, 16'h0000, 0);
    model_check("rnd_rst");
    tick();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 2), 1'($urandom),
            16'($urandom_range(0, 31)), $urandom, 16'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 1));
      model_check($sformatf("rnd%0d", i));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eh2_lsu_amo_wrbuf.md
EH2_LSU_AMO_WRBUF -- requirements
Module: eh2_lsu_amo_wrbuf

Interface
REQ-001 Parameter DEPTH, default 2, number of buffer entries; power of two and at least 2.
REQ-002 Parameter ADDRW, default 16, DCCM byte-address width.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 amo_valid_dc3  input  1  AMO/SC result from the AMO ALU is present in dc3.
REQ-006 flush_dc3  input  1  the dc3 AMO is killed; no push occurs.
REQ-007 amo_tid_dc3  input  1  thread id of the dc3 AMO.
REQ-008 amo_addr_dc3  input  ADDRW  DCCM byte address of the dc3 AMO.
REQ-009 amo_data_dc3  input  32  final AMO store data from the AMO ALU.
REQ-010 lkup_addr_dc2  input  ADDRW  address of the AMO arriving next, used for forwarding lookup.
REQ-011 amo_stall_dc3  output  1  buffer full; upstream holds the dc3 AMO.
REQ-012 fwd_hit_dc2  output  1  lkup_addr_dc2 matches a pending write.
REQ-013 fwd_data_dc2  output  32  data of the youngest matching pending write.
REQ-014 dccm_wr_req  output  1  head entry requests a DCCM write.
REQ-015 dccm_wr_ready  input  1  DCCM write port accepts the request this cycle.
REQ-016 dccm_wr_addr  output  ADDRW  head entry address.
REQ-017 dccm_wr_data  output  32  head entry data.
REQ-018 dccm_wr_tid  output  1  head entry thread id.
REQ-019 amo_buf_empty  output  1  no pending entries; used by fence and halt logic.

Function
REQ-020 The buffer SHALL be an in-order FIFO with rd_ptr and wr_ptr (log2(DEPTH) bits, wrapping modulo DEPTH) and count (0..DEPTH).
REQ-021 push = amo_valid_dc3 & ~flush_dc3 & ~amo_stall_dc3; a push writes tid, addr and data at wr_ptr and advances wr_ptr.
REQ-022 amo_stall_dc3 SHALL equal (count == DEPTH), is combinational, and does not consider a same-cycle pop.
REQ-023 An AMO that arrives while full is not captured, is not lost, and is held upstream.
REQ-024 dccm_wr_req = (count != 0); dccm_wr_addr, dccm_wr_data and dccm_wr_tid come from the rd_ptr entry.
REQ-025 pop = dccm_wr_req & dccm_wr_ready; a pop advances rd_ptr.
REQ-026 While dccm_wr_req=1 and dccm_wr_ready=0, all dccm_wr_* outputs SHALL hold stable.
REQ-027 On simultaneous push and pop, count is unchanged and both pointers advance.
REQ-028 dccm_wr_ready while empty SHALL have no effect.
REQ-029 Latency: a push in cycle N makes dccm_wr_req=1 in cycle N+1 when the buffer was empty.
REQ-030 Address match SHALL compare word addresses, bits [ADDRW-1:2].
REQ-031 Forward candidates: all valid entries, plus the same-cycle push (youngest).
REQ-032 fwd_data_dc2 SHALL come from the youngest matching candidate; fwd_hit_dc2 = any match.
REQ-033 An entry being popped in the current cycle SHALL still forward in that cycle.
REQ-034 fwd_data_dc2 = 0 when fwd_hit_dc2 = 0.
REQ-035 amo_buf_empty = (count == 0).
REQ-036 The thread id SHALL NOT qualify forwarding or ordering; DCCM is shared between threads.

Reset
REQ-037 While rst=1, count, rd_ptr and wr_ptr SHALL be 0 on the next edge, and entry valid bits cleared.
REQ-038 While rst=1 and after it: dccm_wr_req=0, amo_stall_dc3=0, fwd_hit_dc2=0, amo_buf_empty=1, and data outputs 0.
REQ-039 Reset mid-operation SHALL discard pending entries, including a head stalled on dccm_wr_ready=0; no write is issued after reset.
REQ-040 A push asserted in the reset cycle SHALL be ignored.

Verification
REQ-041 Single AMO, empty buffer: push addr 0x0100, data 0xDEADBEEF, ready=1 -> next cycle dccm_wr_req=1 with addr 0x0100, data 0xDEADBEEF; following cycle amo_buf_empty=1.
REQ-042 Back-pressure: push 0x11111111 then 0x22222222 with ready=0 -> stall=1, and a third valid is not captured; ready=1 for two cycles -> writes in order 0x11111111, 0x22222222, then empty.
REQ-043 Forwarding priority: entries at 0x0200 (data 0xA) and 0x0204 (data 0xB), plus a push to 0x0202 (data 0xC) with lkup_addr_dc2=0x0201 -> fwd_hit_dc2=1, fwd_data_dc2=0xC.
REQ-044 Flush: amo_valid_dc3=1 with flush_dc3=1 -> no push, count unchanged, no forward from that op.
REQ-045 Wrap and simultaneous events: DEPTH=2, 10 back-to-back pushes with ready=1 every cycle -> count stays at 1 or below, and all 10 writes appear in order with correct data.
REQ-046 Reset mid-drain: 2 entries pending, ready=0, assert rst for 1 cycle -> dccm_wr_req=0 and amo_buf_empty=1; no write appears after ready=1.
